// File: rtl/oam_mem.sv
// oam_mem: sprite attribute memory shared by CPU, DMA and PPU ports.
// Define OAM_CLEAR_EN to zero the whole array after every reset release.
module oam_mem #(
    parameter int NUM_ENTRIES = 40,
    parameter int ENTRY_BYTES = 4,
    parameter int ADDR_W      = 8,
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_en,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [7:0]               cpu_din,
    output logic [7:0]               cpu_dout,
    input  logic                     ppu_lock,
    input  logic                     ppu_rd_en,
    input  logic [IDX_W-1:0]         ppu_idx,
    output logic [8*ENTRY_BYTES-1:0] ppu_entry,
    output logic                     ppu_valid,
    input  logic                     dma_valid,
    output logic                     dma_ready,
    input  logic [ADDR_W-1:0]        dma_addr,
    input  logic [7:0]               dma_data,
    output logic                     busy
);

    localparam int DEPTH = NUM_ENTRIES * ENTRY_BYTES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W:0]  NUM_I   = (IDX_W+1)'(NUM_ENTRIES);

    logic [7:0] mem [DEPTH];

    logic          dma_acc;
    logic          dma_ok;
    logic          cpu_in;
    logic          cpu_ok;
    logic          cpu_rd_ok;
    logic          ppu_ok;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    logic [AW-1:0] rd_base;

`ifdef OAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          busy_q;

    // Sweep every byte to zero once reset is released; reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign dma_ready = !busy;
    assign dma_acc   = dma_valid & dma_ready;
    assign dma_ok    = dma_acc & ({1'b0, dma_addr} < DEPTH_A);
    assign cpu_in    = ({1'b0, cpu_addr} < DEPTH_A);
    assign cpu_ok    = cpu_en & cpu_we & !ppu_lock & !busy
                     & !dma_acc & cpu_in;
    assign cpu_rd_ok = cpu_en & !cpu_we & !ppu_lock & !busy
                     & !dma_acc & cpu_in;
    assign ppu_ok    = ppu_rd_en & !busy & ({1'b0, ppu_idx} < NUM_I);
    assign rd_base   = AW'(ppu_idx * ENTRY_BYTES);

    // Single write port: clear beats DMA, DMA beats CPU, reset blocks all.
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        if (!reset_n) begin
            we = 1'b0;
        end else if (clr_we) begin
            we = 1'b1;
            wa = clr_addr;
            wd = 8'h00;
        end else if (dma_ok) begin
            we = 1'b1;
            wa = dma_addr[AW-1:0];
            wd = dma_data;
        end else if (cpu_ok) begin
            we = 1'b1;
            wa = cpu_addr[AW-1:0];
            wd = cpu_din;
        end
    end

    // Array update; reads elsewhere see the pre-write value this cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // CPU read data, forced to FF whenever the CPU cannot see the array.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_dout <= 8'hFF;
        end else if (cpu_rd_ok) begin
            cpu_dout <= mem[cpu_addr[AW-1:0]];
        end else begin
            cpu_dout <= 8'hFF;
        end
    end

    // Whole-entry fetch for the PPU; entry holds when no valid request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ppu_entry <= '0;
            ppu_valid <= 1'b0;
        end else begin
            ppu_valid <= ppu_ok;
            if (ppu_ok) begin
                for (int b = 0; b < ENTRY_BYTES; b++) begin
                    ppu_entry[8*b +: 8] <= mem[rd_base + AW'(b)];
                end
            end
        end
    end

endmodule
